// File: rtl/swo_capture_ctrl_if.sv
// Word output bus of the SWO capture controller toward the trace word FIFO.
// valid/ready: a word transfers on a clk edge where wordValid && wordReady; while
// wordValid is high and wordReady low, wordData/wordBytes hold steady.
interface swo_capture_ctrl_if;
  logic [31:0] wordData;
  logic [2:0]  wordBytes;
  logic        wordValid;
  logic        wordReady;

  modport master (output wordData, output wordBytes, output wordValid, input wordReady);
  modport slave  (input wordData, input wordBytes, input wordValid, output wordReady);
endinterface

// File: rtl/swo_capture_ctrl.sv
// Sequences the SWO Manchester decoder and packs its toggle-strobed bytes
// little-endian into 32-bit words, flushing partial words on idle or disable.
module swo_capture_ctrl #(
  parameter int unsigned IDLE_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  output logic               decRst,
  input  logic               byteAvail,
  input  logic [7:0]         completeByte,
  swo_capture_ctrl_if.master word,
  output logic [15:0]        overflowCount,
  output logic               active,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [15:0] TIMEOUT_C = 16'(IDLE_TIMEOUT);

  state_t      state_q, state_d;
  logic        bav_prev_q;
  logic [31:0] pack_q, pack_d;
  logic [2:0]  pack_cnt_q, pack_cnt_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic [31:0] word_data_q, word_data_d;
  logic [2:0]  word_bytes_q, word_bytes_d;
  logic        word_valid_q, word_valid_d;
  logic [15:0] ovf_q, ovf_d;
  logic        new_byte, out_free, xfer, byte_taken;

  assign new_byte   = (state_q == RUN) && (byteAvail != bav_prev_q);
  assign out_free   = !word_valid_q || word.wordReady;
  assign xfer       = out_free && ((pack_cnt_q == 3'd4) ||
                                   ((pack_cnt_q != 3'd0) && (idle_cnt_q >= TIMEOUT_C)) ||
                                   ((state_q == DRAIN) && (pack_cnt_q != 3'd0)));
  assign byte_taken = new_byte && (xfer || (pack_cnt_q < 3'd4));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OFF:     if (enable) state_d = START;
      START:   state_d = RUN;
      RUN:     if (!enable) state_d = DRAIN;
      DRAIN:   if ((pack_cnt_q == 3'd0) && out_free) state_d = OFF;
      default: state_d = OFF;
    endcase
  end

  always_comb begin
    pack_d       = pack_q;
    pack_cnt_d   = pack_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    word_data_d  = word_data_q;
    word_bytes_d = word_bytes_q;
    word_valid_d = word_valid_q;
    ovf_d        = ovf_q;

    if (word_valid_q && word.wordReady) word_valid_d = 1'b0;
    if (xfer) begin
      word_data_d  = pack_q;
      word_bytes_d = pack_cnt_q;
      word_valid_d = 1'b1;
      pack_d       = '0;
      pack_cnt_d   = 3'd0;
    end

    // A byte arriving with a transfer starts the next word, so none is lost.
    if (new_byte) begin
      if (xfer) begin
        pack_d     = {24'h0, completeByte};
        pack_cnt_d = 3'd1;
      end else if (pack_cnt_q < 3'd4) begin
        pack_d[{pack_cnt_q[1:0], 3'b000} +: 8] = completeByte;
        pack_cnt_d = pack_cnt_q + 3'd1;
      end else if (ovf_q != 16'hFFFF) begin
        ovf_d = ovf_q + 16'd1;
      end
    end

    if (xfer || byte_taken || (pack_cnt_q == 3'd0)) idle_cnt_d = 16'd0;
    else if ((pack_cnt_q < 3'd4) && (idle_cnt_q != 16'hFFFF)) idle_cnt_d = idle_cnt_q + 16'd1;
  end

  // The decoder strobe has no reset value, so its history is tracked unconditionally.
  always_ff @(posedge clk) begin
    bav_prev_q <= byteAvail;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= OFF;
      pack_q       <= '0;
      pack_cnt_q   <= 3'd0;
      idle_cnt_q   <= 16'd0;
      word_data_q  <= '0;
      word_bytes_q <= 3'd0;
      word_valid_q <= 1'b0;
      ovf_q        <= 16'd0;
    end else begin
      state_q      <= state_d;
      pack_q       <= pack_d;
      pack_cnt_q   <= pack_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      word_data_q  <= word_data_d;
      word_bytes_q <= word_bytes_d;
      word_valid_q <= word_valid_d;
      ovf_q        <= ovf_d;
    end
  end

  assign decRst         = (state_q != RUN);
  assign active         = (state_q == RUN);
  assign dbg_state      = state_q;
  assign overflowCount  = ovf_q;
  assign word.wordData  = word_data_q;
  assign word.wordBytes = word_bytes_q;
  assign word.wordValid = word_valid_q;

endmodule

// File: doc/swo_capture_ctrl.md
Name: swo_capture_ctrl

Overview:
Controller that sequences the SWO Manchester decoder and packs its byte stream into 32-bit words for the trace output FIFO. It holds the decoder in reset while capture is disabled and resynchronises to the decoder's toggling byte strobe on start. It packs bytes little-endian, flushes partial words on idle timeout or disable, and counts bytes dropped under back-pressure. It sits between the decoder's byteAvail/completeByte outputs and the downstream word FIFO.

Parameters:
IDLE_TIMEOUT, 1024, clock cycles with no new byte before a partial word (1-3 bytes) is flushed; legal range 2..65535.

Ports:
clk  input  1  module clock; the decoder runs on the same clock.
rst  input  1  synchronous, active-low reset (rst==0 at a clk edge resets the block).
enable  input  1  level; 1 = capture on, 0 = capture off.
decRst  output  1  active-high reset driven to the decoder.
byteAvail  input  1  decoder toggle strobe; each change means a new byte is present.
completeByte  input  8  decoder byte; valid when byteAvail changes.
wordData  output  32  packed word; byte k in bits [8k+7:8k].
wordBytes  output  3  number of valid bytes in wordData, 1..4.
wordValid  output  1  output word valid.
wordReady  input  1  downstream accepts the word.
overflowCount  output  16  saturating count of dropped bytes.
active  output  1  1 in RUN state.

Behaviour:
- Reset (rst==0): state OFF, decRst=1, wordValid=0, wordData=0, wordBytes=0, overflowCount=0, active=0. Pack register, pack count and idle counter are cleared. A reset mid-operation discards the pack and any held output word without handshake.
- States:
  - OFF: decRst=1. enable=1 -> START.
  - START: lasts exactly 1 cycle. decRst=1, bavPrev<=byteAvail. Next state RUN.
  - RUN: decRst=0, active=1. enable=0 -> DRAIN.
  - DRAIN: decRst=1. Accepts no bytes. Go to OFF when pack count==0 and wordValid==0 (or the current word is being accepted this cycle). A partial pack is flushed without waiting for the timeout.
- Byte detect: newByte = (state==RUN) && (byteAvail != bavPrev).
  - bavPrev<=byteAvail every cycle in every state, so toggles from before or during START are ignored.
  - The decoder's byteAvail has no reset value and is not relied on.
- Output free: outFree = !wordValid || wordReady.
- Transfer condition: xfer = outFree && (packCnt==4 || (packCnt!=0 && idleCnt>=IDLE_TIMEOUT) || (state==DRAIN && packCnt!=0)).
  - On xfer: wordData<=pack, wordBytes<=packCnt, wordValid<=1, packCnt<=0.
  - Unused upper bytes of wordData are 0.
- Handshake:
  - If wordValid && wordReady and there is no xfer, wordValid<=0.
  - wordData and wordBytes stay stable while wordValid && !wordReady.
- Byte intake on newByte:
  - With xfer in the same cycle: the byte goes to pack slot 0 and packCnt<=1.
  - Else if packCnt<4: the byte goes to slot packCnt and packCnt increments.
  - Else (pack full, output blocked): the byte is dropped and overflowCount increments, saturating at 16'hFFFF.
- Idle counter:
  - Cleared on xfer or on any accepted byte.
  - Otherwise increments, saturating, while packCnt is 1..3.
  - Held at 0 while packCnt==0.
- Latency:
  - The 4th byte's toggle is seen at edge E (pack full).
  - wordValid is high after edge E+1 if the output was free.
  - Partial flush: wordValid is high IDLE_TIMEOUT+1 edges after the last byte's edge.
- Enable re-asserted in DRAIN: DRAIN completes to OFF, then START follows. There is no direct DRAIN->RUN transition.

Test Plan:
1. Reset, enable=1, 4 byte toggles with 0x11,0x22,0x33,0x44 and wordReady=1 -> one word 0x44332211, wordBytes=4, wordValid high for exactly 1 cycle; decRst=0 from 2nd cycle after enable.
2. Toggle byteAvail while OFF and during START -> no bytes captured, pack empty, wordValid stays 0.
3. IDLE_TIMEOUT=16, 2 bytes 0xAA,0xBB then silence -> word 0x0000BBAA, wordBytes=2, wordValid high 17 edges after 2nd byte.
4. wordReady=0, send 9 bytes -> first word held stable, pack full, 9th byte dropped, overflowCount=1. Then wordReady=1 -> 0x..(bytes1-4), then bytes 5-8 delivered in order.
5. RUN with 3 bytes packed, enable=0 -> decRst=1 next cycle; partial word with wordBytes=3 emitted; state OFF after acceptance; active=0.
6. Assert rst=0 while wordValid=1 and wordReady=0 -> next cycle wordValid=0, overflowCount=0, decRst=1, state OFF.
